// File: rtl/sram_resp_pkg.sv
// Shared defaults and clear-FSM state encoding for the SRAM responder.
package sram_resp_pkg;

    localparam int unsigned DEFAULT_DEPTH_LOG2 = 12;
    localparam logic [31:0] DEFAULT_BASE_ADDR  = 32'h1C00_0000;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } clear_state_e;

endpackage

// File: rtl/sram_resp_clear_fsm.sv
// Post-reset array clear sequencer: walks every word index once, then idles in READY.
// ENABLE=0 keeps busy and the clear strobe permanently low.
module sram_resp_clear_fsm
    import sram_resp_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2 = DEFAULT_DEPTH_LOG2,
    parameter bit          ENABLE     = 1'b1
) (
    input  logic                  clk,
    input  logic                  resetn,
    output logic                  busy,
    output logic [DEPTH_LOG2-1:0] clear_idx,
    output logic                  clear_we_c
);

    clear_state_e          state, state_nxt;
    logic [DEPTH_LOG2-1:0] idx_nxt;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state     <= CLEAR;
            clear_idx <= '0;
        end else begin
            state     <= state_nxt;
            clear_idx <= idx_nxt;
        end
    end

    // The last index is written in the same cycle the FSM leaves CLEAR.
    always_comb begin
        state_nxt = state;
        idx_nxt   = clear_idx;
        unique case (state)
            CLEAR: begin
                idx_nxt = clear_idx + DEPTH_LOG2'(1);
                if (clear_idx == '1) begin
                    state_nxt = READY;
                end
            end
            READY: begin
                state_nxt = READY;
            end
        endcase
    end

    assign busy       = ENABLE && (state == CLEAR);
    // No clear write lands on a reset edge, so reset alone never alters the array.
    assign clear_we_c = busy && resetn;

endmodule

// File: rtl/sram_responder.sv
// Single-cycle 32-bit SRAM slave: byte-lane writes, read-first data, range check and access counters.
// Define SRAM_RESP_CLEAR_EN to zero the array after every reset (busy is high while clearing).
module sram_responder
    import sram_resp_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2 = DEFAULT_DEPTH_LOG2,
    parameter logic [31:0] BASE_ADDR  = DEFAULT_BASE_ADDR
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        sram_en,
    input  logic [3:0]  sram_we,
    input  logic [31:0] sram_addr,
    input  logic [31:0] sram_wdata,
    output logic [31:0] sram_rdata,
    output logic        busy,
    output logic        addr_err,
    output logic [31:0] rd_cnt,
    output logic [31:0] wr_cnt
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

`ifdef SRAM_RESP_CLEAR_EN
    localparam bit CLEAR_EN = 1'b1;
`else
    localparam bit CLEAR_EN = 1'b0;
`endif

    logic [31:0]           mem [DEPTH];
    logic [DEPTH_LOG2-1:0] idx_c;
    logic [DEPTH_LOG2-1:0] clear_idx;
    logic                  clear_we_c;
    logic                  in_range_c;
    logic                  req_c;
    logic                  rd_hit_c;
    logic                  wr_hit_c;
    logic [31:0]           merged_c;
    logic                  unused_ok;

    sram_resp_clear_fsm #(
        .DEPTH_LOG2 (DEPTH_LOG2),
        .ENABLE     (CLEAR_EN)
    ) u_clear (
        .clk        (clk),
        .resetn     (resetn),
        .busy       (busy),
        .clear_idx  (clear_idx),
        .clear_we_c (clear_we_c)
    );

    // Byte offset within a word carries no meaning for this array.
    assign unused_ok = &{1'b0, sram_addr[1:0]};

    assign idx_c      = sram_addr[DEPTH_LOG2+1:2];
    assign in_range_c = (sram_addr[31:DEPTH_LOG2+2] == BASE_ADDR[31:DEPTH_LOG2+2]);
    assign req_c      = resetn && sram_en && !busy;
    assign rd_hit_c   = req_c && in_range_c && (sram_we == 4'h0);
    assign wr_hit_c   = req_c && in_range_c && (sram_we != 4'h0);

    always_comb begin
        merged_c = mem[idx_c];
        for (int b = 0; b < 4; b++) begin
            if (sram_we[b]) begin
                merged_c[8*b +: 8] = sram_wdata[8*b +: 8];
            end
        end
    end

    // Array has no reset; clear and request writes never coincide because requests stall on busy.
    always_ff @(posedge clk) begin
        if (clear_we_c) begin
            mem[clear_idx] <= '0;
        end else if (wr_hit_c) begin
            mem[idx_c] <= merged_c;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            sram_rdata <= '0;
            addr_err   <= 1'b0;
            rd_cnt     <= '0;
            wr_cnt     <= '0;
        end else begin
            addr_err <= 1'b0;
            if (busy) begin
                sram_rdata <= '0;
            end else if (sram_en) begin
                if (in_range_c) begin
                    sram_rdata <= mem[idx_c];
                end else begin
                    sram_rdata <= '0;
                    addr_err   <= 1'b1;
                end
            end
            if (rd_hit_c && (rd_cnt != '1)) begin
                rd_cnt <= rd_cnt + 32'(1);
            end
            if (wr_hit_c && (wr_cnt != '1)) begin
                wr_cnt <= wr_cnt + 32'(1);
            end
        end
    end

endmodule

// File: tb/tb_sram_responder.sv
// Directed self-checking bench for sram_responder (DEPTH_LOG2=4, default base address).
module tb_sram_responder;

    localparam int unsigned DL2  = 4;
    localparam logic [31:0] BASE = 32'h1C00_0000;
`ifdef SRAM_RESP_CLEAR_EN
    localparam int BUSY_CYC = 16;
`else
    localparam int BUSY_CYC = 0;
`endif

    logic        clk = 1'b0;
    logic        resetn;
    logic        sram_en;
    logic [3:0]  sram_we;
    logic [31:0] sram_addr;
    logic [31:0] sram_wdata;
    logic [31:0] sram_rdata;
    logic        busy;
    logic        addr_err;
    logic [31:0] rd_cnt;
    logic [31:0] wr_cnt;

    int          nvec = 0;
    int          nerr = 0;
    logic [31:0] mdl_rd;
    logic [31:0] mdl_wr;

    always #5 clk = ~clk;

    sram_responder #(
        .DEPTH_LOG2 (DL2),
        .BASE_ADDR  (BASE)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .sram_en    (sram_en),
        .sram_we    (sram_we),
        .sram_addr  (sram_addr),
        .sram_wdata (sram_wdata),
        .sram_rdata (sram_rdata),
        .busy       (busy),
        .addr_err   (addr_err),
        .rd_cnt     (rd_cnt),
        .wr_cnt     (wr_cnt)
    );

    // One access across one rising edge; outputs are sampled at the following negedge.
    task automatic access(input logic [3:0] we, input logic [31:0] addr, input logic [31:0] wd);
        sram_en    = 1'b1;
        sram_we    = we;
        sram_addr  = addr;
        sram_wdata = wd;
        if (addr[31:DL2+2] == BASE[31:DL2+2]) begin
            if (we == 4'h0) mdl_rd = mdl_rd + 32'd1;
            else            mdl_wr = mdl_wr + 32'd1;
        end
        @(negedge clk);
        sram_en = 1'b0;
        sram_we = 4'h0;
    endtask

    task automatic idle(input int n);
        sram_en = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        sram_en = 1'b0;
        sram_we = 4'h0;
        resetn  = 1'b0;
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        mdl_rd = '0;
        mdl_wr = '0;
        for (int i = 0; i < 64 && busy === 1'b1; i++) @(negedge clk);
        nvec++;
        if (busy !== 1'b0) begin
            nerr++;
            $display("FAIL reset_ready_timeout busy=%b want 0", busy);
        end
    endtask

    task automatic test_reset();
        logic exp_busy;
        exp_busy   = (BUSY_CYC != 0);
        resetn     = 1'b0;
        sram_en    = 1'b1;
        sram_we    = 4'h0;
        sram_addr  = 32'h1D00_0000;
        sram_wdata = '0;
        repeat (2) @(negedge clk);
        sram_en = 1'b0;
        nvec++; if (sram_rdata !== 32'h0) begin nerr++; $display("FAIL reset_rdata got=%h want=0", sram_rdata); end
        nvec++; if (addr_err !== 1'b0) begin nerr++; $display("FAIL reset_addr_err got=%b want=0", addr_err); end
        nvec++; if (rd_cnt !== 32'h0) begin nerr++; $display("FAIL reset_rd_cnt got=%h want=0", rd_cnt); end
        nvec++; if (wr_cnt !== 32'h0) begin nerr++; $display("FAIL reset_wr_cnt got=%h want=0", wr_cnt); end
        nvec++; if (busy !== exp_busy) begin nerr++; $display("FAIL reset_busy got=%b want=%b", busy, exp_busy); end
    endtask

    task automatic test_clear();
        int bad;
        bad     = 0;
        sram_en = 1'b0;
        resetn  = 1'b1;
        mdl_rd  = '0;
        mdl_wr  = '0;
        for (int i = 0; i < 30; i++) begin
            if (busy !== (i < BUSY_CYC)) bad++;
            @(negedge clk);
        end
        nvec++; if (bad != 0) begin nerr++; $display("FAIL clear_busy_window bad_samples=%0d want 0 (busy cycles=%0d)", bad, BUSY_CYC); end
`ifndef SRAM_RESP_CLEAR_EN
        access(4'hF, 32'h1C00_0008, 32'h0);
`endif
        access(4'h0, 32'h1C00_0008, 32'h0);
        nvec++; if (sram_rdata !== 32'h0) begin nerr++; $display("FAIL clear_read got=%h want=0", sram_rdata); end
    endtask

    task automatic test_byte_write();
        access(4'hF, 32'h1C00_0004, 32'hDEAD_BEEF);
        access(4'b0010, 32'h1C00_0004, 32'h0000_5500);
        nvec++; if (sram_rdata !== 32'hDEAD_BEEF) begin nerr++; $display("FAIL byte_prewrite got=%h want=deadbeef", sram_rdata); end
        access(4'h0, 32'h1C00_0004, 32'h0);
        nvec++; if (sram_rdata !== 32'hDEAD_55EF) begin nerr++; $display("FAIL byte_merge got=%h want=dead55ef", sram_rdata); end
        access(4'h0, 32'h1C00_0007, 32'h0);
        nvec++; if (sram_rdata !== 32'hDEAD_55EF) begin nerr++; $display("FAIL byte_offset_ignored got=%h want=dead55ef", sram_rdata); end
    endtask

    task automatic test_read_first();
        access(4'hF, 32'h1C00_0000, 32'h1111_1111);
        access(4'hF, 32'h1C00_0000, 32'h2222_2222);
        nvec++; if (sram_rdata !== 32'h1111_1111) begin nerr++; $display("FAIL read_first got=%h want=11111111", sram_rdata); end
        access(4'h0, 32'h1C00_0000, 32'h0);
        nvec++; if (sram_rdata !== 32'h2222_2222) begin nerr++; $display("FAIL write_then_read got=%h want=22222222", sram_rdata); end
        access(4'hF, 32'h1C00_003C, 32'h5A5A_5A5A);
        access(4'h0, 32'h1C00_003C, 32'h0);
        nvec++; if (sram_rdata !== 32'h5A5A_5A5A) begin nerr++; $display("FAIL top_word got=%h want=5a5a5a5a", sram_rdata); end
        nvec++; if (addr_err !== 1'b0) begin nerr++; $display("FAIL top_word_err got=%b want=0", addr_err); end
    endtask

    task automatic test_range();
        access(4'h0, 32'h1D00_0000, 32'h0);
        nvec++; if (addr_err !== 1'b1) begin nerr++; $display("FAIL range_rd_err got=%b want=1", addr_err); end
        nvec++; if (sram_rdata !== 32'h0) begin nerr++; $display("FAIL range_rd_data got=%h want=0", sram_rdata); end
        nvec++; if (rd_cnt !== mdl_rd) begin nerr++; $display("FAIL range_rd_cnt got=%h want=%h", rd_cnt, mdl_rd); end
        idle(1);
        nvec++; if (addr_err !== 1'b0) begin nerr++; $display("FAIL range_err_pulse got=%b want=0", addr_err); end
        nvec++; if (sram_rdata !== 32'h0) begin nerr++; $display("FAIL range_hold got=%h want=0", sram_rdata); end
        access(4'hF, 32'h1D00_0000, 32'hCAFE_F00D);
        nvec++; if (addr_err !== 1'b1) begin nerr++; $display("FAIL range_wr_err got=%b want=1", addr_err); end
        access(4'hF, 32'h1C00_0040, 32'h0BAD_BEEF);
        nvec++; if (addr_err !== 1'b1) begin nerr++; $display("FAIL range_edge_err got=%b want=1", addr_err); end
        nvec++; if (wr_cnt !== mdl_wr) begin nerr++; $display("FAIL range_wr_cnt got=%h want=%h", wr_cnt, mdl_wr); end
        access(4'h0, 32'h1C00_0000, 32'h0);
        nvec++; if (addr_err !== 1'b0) begin nerr++; $display("FAIL range_clear_err got=%b want=0", addr_err); end
        nvec++; if (sram_rdata !== 32'h2222_2222) begin nerr++; $display("FAIL range_no_write got=%h want=22222222", sram_rdata); end
    endtask

    task automatic test_hold_counters();
        int bad;
        bad = 0;
        do_reset();
        access(4'hF, 32'h1C00_0008, 32'h0A0B_0C0D);
        access(4'hF, 32'h1C00_0014, 32'hAABB_CCDD);
        access(4'h0, 32'h1C00_0008, 32'h0);
        nvec++; if (sram_rdata !== 32'h0A0B_0C0D) begin nerr++; $display("FAIL cnt_rd0 got=%h want=0a0b0c0d", sram_rdata); end
        access(4'h0, 32'h1C00_0014, 32'h0);
        nvec++; if (sram_rdata !== 32'hAABB_CCDD) begin nerr++; $display("FAIL cnt_rd1 got=%h want=aabbccdd", sram_rdata); end
        access(4'h0, 32'h1C00_0008, 32'h0);
        for (int i = 0; i < 5; i++) begin
            if (sram_rdata !== 32'h0A0B_0C0D) bad++;
            sram_we    = 4'hF;
            sram_wdata = 32'hFFFF_FFFF;
            idle(1);
        end
        sram_we = 4'h0;
        nvec++; if (bad != 0) begin nerr++; $display("FAIL hold_rdata bad_samples=%0d want 0 last=%h", bad, sram_rdata); end
        nvec++; if (rd_cnt !== 32'd3) begin nerr++; $display("FAIL rd_cnt got=%0d want=3", rd_cnt); end
        nvec++; if (wr_cnt !== 32'd2) begin nerr++; $display("FAIL wr_cnt got=%0d want=2", wr_cnt); end
        force dut.rd_cnt = 32'hFFFF_FFFF;
        #1;
        release dut.rd_cnt;
        access(4'h0, 32'h1C00_0014, 32'h0);
        nvec++; if (rd_cnt !== 32'hFFFF_FFFF) begin nerr++; $display("FAIL rd_cnt_saturate got=%h want=ffffffff", rd_cnt); end
        nvec++; if (wr_cnt !== 32'd2) begin nerr++; $display("FAIL wr_cnt_after_sat got=%0d want=2", wr_cnt); end
    endtask

`ifdef SRAM_RESP_CLEAR_EN
    task automatic test_reset_mid();
        int bad_busy;
        int bad_req;
        bad_busy = 0;
        bad_req  = 0;
        sram_en  = 1'b0;
        resetn   = 1'b0;
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        repeat (7) @(negedge clk);
        resetn = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        mdl_rd = '0;
        mdl_wr = '0;
        for (int i = 0; i < 30; i++) begin
            if (busy !== (i < BUSY_CYC)) bad_busy++;
            if (i < 12 && (addr_err !== 1'b0 || sram_rdata !== 32'h0)) bad_req++;
            sram_en    = (i < 10);
            sram_we    = (i % 2 == 0) ? 4'hF : 4'h0;
            sram_addr  = (i % 2 == 0) ? 32'h1C00_0008 : 32'h1D00_0000;
            sram_wdata = 32'hFFFF_FFFF;
            @(negedge clk);
        end
        sram_en = 1'b0;
        sram_we = 4'h0;
        nvec++; if (bad_busy != 0) begin nerr++; $display("FAIL midclear_busy bad_samples=%0d want 0", bad_busy); end
        nvec++; if (bad_req != 0) begin nerr++; $display("FAIL midclear_ignored bad_samples=%0d want 0", bad_req); end
        nvec++; if (rd_cnt !== 32'h0) begin nerr++; $display("FAIL midclear_rd_cnt got=%h want=0", rd_cnt); end
        nvec++; if (wr_cnt !== 32'h0) begin nerr++; $display("FAIL midclear_wr_cnt got=%h want=0", wr_cnt); end
        access(4'h0, 32'h1C00_0008, 32'h0);
        nvec++; if (sram_rdata !== 32'h0) begin nerr++; $display("FAIL midclear_cleared got=%h want=0", sram_rdata); end
    endtask
`else
    task automatic test_reset_mid();
        access(4'hF, 32'h1C00_0008, 32'h1357_2468);
        resetn     = 1'b0;
        sram_en    = 1'b1;
        sram_we    = 4'hF;
        sram_addr  = 32'h1C00_0014;
        sram_wdata = 32'hFFFF_FFFF;
        @(negedge clk);
        sram_en = 1'b0;
        sram_we = 4'h0;
        nvec++; if (rd_cnt !== 32'h0) begin nerr++; $display("FAIL midtraffic_rd_cnt got=%h want=0", rd_cnt); end
        nvec++; if (wr_cnt !== 32'h0) begin nerr++; $display("FAIL midtraffic_wr_cnt got=%h want=0", wr_cnt); end
        nvec++; if (sram_rdata !== 32'h0) begin nerr++; $display("FAIL midtraffic_rdata got=%h want=0", sram_rdata); end
        resetn = 1'b1;
        mdl_rd = '0;
        mdl_wr = '0;
        access(4'h0, 32'h1C00_0014, 32'h0);
        nvec++; if (sram_rdata !== 32'hAABB_CCDD) begin nerr++; $display("FAIL midtraffic_retained got=%h want=aabbccdd", sram_rdata); end
        nvec++; if (busy !== 1'b0) begin nerr++; $display("FAIL midtraffic_busy got=%b want=0", busy); end
        nvec++; if (rd_cnt !== 32'd1) begin nerr++; $display("FAIL midtraffic_first_read got=%0d want=1", rd_cnt); end
    endtask
`endif

    initial begin
        resetn     = 1'b0;
        sram_en    = 1'b0;
        sram_we    = 4'h0;
        sram_addr  = '0;
        sram_wdata = '0;
        mdl_rd     = '0;
        mdl_wr     = '0;
        @(negedge clk);
        test_reset();
        test_clear();
        test_byte_write();
        test_read_first();
        test_range();
        test_hold_counters();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
